// File: rtl/vsrc_pkg.sv
// vsrc_pkg: pattern codes and axis timing helpers for the synthetic video source
package vsrc_pkg;
  typedef enum logic [1:0] {
    PAT_SOLID = 2'd0,
    PAT_HRAMP = 2'd1,
    PAT_VRAMP = 2'd2,
    PAT_CHECK = 2'd3
  } pat_t;
  function automatic int axis_total(input int s, input int bp, input int act, input int fp);
    return s + bp + act + fp;
  endfunction
  function automatic int axis_width(input int s, input int bp, input int act, input int fp);
    return $clog2(axis_total(s, bp, act, fp));
  endfunction
endpackage

// File: rtl/vtg_axis_counter.sv
// vtg_axis_counter: one timing axis (sync, back porch, active, front porch) with wrap strobe
module vtg_axis_counter
  import vsrc_pkg::*;
#(
  parameter int SYNC = 96,
  parameter int BP = 152,
  parameter int ACT = 800,
  parameter int FP = 32,
  localparam int TOTAL = axis_total(SYNC, BP, ACT, FP),
  localparam int W = axis_width(SYNC, BP, ACT, FP)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         adv,
  output logic [W-1:0] cnt,
  output logic         sync,
  output logic         act,
  output logic         wrap
);
  always_comb begin
    wrap = adv && (32'(cnt) == TOTAL - 1);
    sync = 32'(cnt) < SYNC;
    act = (32'(cnt) >= SYNC + BP) && (32'(cnt) < SYNC + BP + ACT);
  end
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (adv) cnt <= wrap ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/vsrc_pattern.sv
// vsrc_pattern: synthetic video timing generator and test-pattern source
module vsrc_pattern
  import vsrc_pkg::*;
#(
  parameter int H_FP = 32,
  parameter int H_SYNC = 96,
  parameter int H_BP = 152,
  parameter int H_ACT = 800,
  parameter int V_FP = 1,
  parameter int V_SYNC = 3,
  parameter int V_BP = 46,
  parameter int V_ACT = 1200,
  parameter logic [7:0] SOLID_LEVEL = 8'h80
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  pattern,
  output logic        v_vsync,
  output logic        v_hsync,
  output logic        v_de,
  output logic [7:0]  v_pixel,
  output logic [15:0] frame_count
);
  localparam int HW = axis_width(H_SYNC, H_BP, H_ACT, H_FP);
  localparam int VW = axis_width(V_SYNC, V_BP, V_ACT, V_FP);
  logic [HW-1:0] hc;
  logic [VW-1:0] vc;
  logic h_sync, h_act, h_wrap, v_sync, v_act, v_wrap, de;
  logic [7:0] x, y, pix;
  logic [15:0] fc_next;
  pat_t pat_q;
  vtg_axis_counter #(.SYNC(H_SYNC), .BP(H_BP), .ACT(H_ACT), .FP(H_FP)) u_h (
    .clk(clk), .rst(rst), .clr(!enable), .adv(enable),
    .cnt(hc), .sync(h_sync), .act(h_act), .wrap(h_wrap)
  );
  vtg_axis_counter #(.SYNC(V_SYNC), .BP(V_BP), .ACT(V_ACT), .FP(V_FP)) u_v (
    .clk(clk), .rst(rst), .clr(!enable), .adv(h_wrap),
    .cnt(vc), .sync(v_sync), .act(v_act), .wrap(v_wrap)
  );
  always_comb begin
    x = 8'(32'(hc) - 32'(H_SYNC + H_BP));
    y = 8'(32'(vc) - 32'(V_SYNC + V_BP));
    de = h_act && v_act;
    pix = pat_q == PAT_SOLID ? SOLID_LEVEL :
          pat_q == PAT_HRAMP ? x :
          pat_q == PAT_VRAMP ? y : {8{x[3] ^ y[3] ^ frame_count[0]}};
    fc_next = v_wrap ? frame_count + 16'd1 : frame_count;
  end
  // pattern is latched only at the frame origin so a mid-frame change never tears
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q <= PAT_SOLID;
      frame_count <= '0;
      v_vsync <= 1'b0;
      v_hsync <= 1'b0;
      v_de <= 1'b0;
      v_pixel <= 8'h00;
    end else begin
      frame_count <= fc_next;
      if (enable && hc == '0 && vc == '0) pat_q <= pat_t'(pattern);
      v_vsync <= enable && v_sync;
      v_hsync <= enable && h_sync;
      v_de <= enable && de;
      v_pixel <= (enable && de) ? pix : 8'h00;
    end
  end
endmodule

// File: tb/tb_vsrc_pattern.sv
// tb_vsrc_pattern: directed checks of timing, patterns, reset, enable and counter wrap
module tb_vsrc_pattern;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b0;
  logic [1:0] pattern = 2'd0;
  logic v_vsync, v_hsync, v_de;
  logic [7:0] v_pixel;
  logic [15:0] frame_count;
  int errors = 0, checks = 0;
  logic [10:0] frm [98];
  logic [10:0] solid_ref [98];

  vsrc_pattern #(
    .H_FP(2), .H_SYNC(2), .H_BP(2), .H_ACT(8),
    .V_FP(1), .V_SYNC(1), .V_BP(1), .V_ACT(4), .SOLID_LEVEL(8'h80)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .pattern(pattern),
    .v_vsync(v_vsync), .v_hsync(v_hsync), .v_de(v_de), .v_pixel(v_pixel),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic grab(input int n, input int off);
    for (int i = 0; i < n; i++) begin
      step();
      frm[off + i] = {v_vsync, v_hsync, v_de, v_pixel};
    end
  endtask

  // expected {vsync,hsync,de,pixel} for frame position k on a 14x7 raster
  function automatic logic [10:0] expv(input int k, input logic [1:0] p, input logic [15:0] fc);
    int h, v;
    logic d;
    logic [7:0] px, xx, yy;
    h = k % 14;
    v = k / 14;
    d = (h >= 4) && (h < 12) && (v >= 2) && (v < 6);
    xx = 8'(h - 4);
    yy = 8'(v - 2);
    px = p == 2'd0 ? 8'h80 : p == 2'd1 ? xx : p == 2'd2 ? yy : {8{xx[3] ^ yy[3] ^ fc[0]}};
    return {v < 1, h < 2, d, d ? px : 8'h00};
  endfunction

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; pattern = 2'd0;
    repeat (3) step();
    checks++;
    if ({v_vsync, v_hsync, v_de, v_pixel} !== 11'h0) begin
      errors++; $display("FAIL reset_outputs got %h exp %h", {v_vsync, v_hsync, v_de, v_pixel}, 11'h0);
    end
    checks++;
    if (frame_count !== 16'h0) begin
      errors++; $display("FAIL reset_frame_count got %h exp 0000", frame_count);
    end
  endtask

  task automatic test_solid();
    int hs, des;
    rst = 1'b0;
    grab(98, 0);
    hs = 0; des = 0;
    for (int k = 0; k < 98; k++) begin
      solid_ref[k] = frm[k];
      hs += (k / 14 == 3) ? int'(frm[k][9]) : 0;
      des += int'(frm[k][8]);
      checks++;
      if (frm[k] !== expv(k, 2'd0, 16'd0)) begin
        errors++; $display("FAIL solid k=%0d got %h exp %h", k, frm[k], expv(k, 2'd0, 16'd0));
      end
    end
    checks++;
    if (hs != 2) begin errors++; $display("FAIL solid_hsync_width got %0d exp 2", hs); end
    checks++;
    if (des != 32) begin errors++; $display("FAIL solid_de_count got %0d exp 32", des); end
    checks++;
    if (frame_count !== 16'd1) begin errors++; $display("FAIL solid_frame_count got %0d exp 1", frame_count); end
  endtask

  task automatic test_ramps();
    pattern = 2'd1;
    grab(98, 0);
    for (int k = 0; k < 98; k++) begin
      checks++;
      if (frm[k] !== expv(k, 2'd1, 16'd1)) begin
        errors++; $display("FAIL hramp k=%0d got %h exp %h", k, frm[k], expv(k, 2'd1, 16'd1));
      end
    end
    pattern = 2'd2;
    grab(98, 0);
    for (int k = 0; k < 98; k++) begin
      checks++;
      if (frm[k] !== expv(k, 2'd2, 16'd2)) begin
        errors++; $display("FAIL vramp k=%0d got %h exp %h", k, frm[k], expv(k, 2'd2, 16'd2));
      end
    end
    checks++;
    if (frame_count !== 16'd3) begin errors++; $display("FAIL ramps_frame_count got %0d exp 3", frame_count); end
  endtask

  task automatic test_pattern_switch();
    pattern = 2'd1;
    grab(40, 0);
    pattern = 2'd2;
    grab(58, 40);
    for (int k = 0; k < 98; k++) begin
      checks++;
      if (frm[k] !== expv(k, 2'd1, 16'd3)) begin
        errors++; $display("FAIL switch_hold k=%0d got %h exp %h", k, frm[k], expv(k, 2'd1, 16'd3));
      end
    end
    grab(98, 0);
    for (int k = 0; k < 98; k++) begin
      checks++;
      if (frm[k] !== expv(k, 2'd2, 16'd4)) begin
        errors++; $display("FAIL switch_next k=%0d got %h exp %h", k, frm[k], expv(k, 2'd2, 16'd4));
      end
    end
    checks++;
    if (frame_count !== 16'd5) begin errors++; $display("FAIL switch_frame_count got %0d exp 5", frame_count); end
  endtask

  task automatic test_rst_mid();
    grab(47, 0);
    rst = 1'b1;
    step();
    checks++;
    if ({v_vsync, v_hsync, v_de, v_pixel} !== 11'h0) begin
      errors++; $display("FAIL rst_mid_outputs got %h exp %h", {v_vsync, v_hsync, v_de, v_pixel}, 11'h0);
    end
    checks++;
    if (frame_count !== 16'd0) begin errors++; $display("FAIL rst_mid_frame_count got %0d exp 0", frame_count); end
    rst = 1'b0; pattern = 2'd0;
    grab(98, 0);
    for (int k = 0; k < 98; k++) begin
      checks++;
      if (frm[k] !== solid_ref[k]) begin
        errors++; $display("FAIL rst_restart k=%0d got %h exp %h", k, frm[k], solid_ref[k]);
      end
    end
    checks++;
    if (frame_count !== 16'd1) begin errors++; $display("FAIL rst_restart_frame_count got %0d exp 1", frame_count); end
  endtask

  task automatic test_checker();
    rst = 1'b1; pattern = 2'd3;
    step();
    rst = 1'b0;
    for (int f = 0; f < 2; f++) begin
      grab(98, 0);
      for (int k = 0; k < 98; k++) begin
        checks++;
        if (frm[k] !== expv(k, 2'd3, 16'(f))) begin
          errors++; $display("FAIL checker f=%0d k=%0d got %h exp %h", f, k, frm[k], expv(k, 2'd3, 16'(f)));
        end
      end
    end
    checks++;
    if (frame_count !== 16'd2) begin errors++; $display("FAIL checker_frame_count got %0d exp 2", frame_count); end
  endtask

  task automatic test_enable();
    grab(20, 0);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({v_vsync, v_hsync, v_de, v_pixel} !== 11'h0 || frame_count !== 16'd2) begin
        errors++; $display("FAIL enable_idle i=%0d got %h/%0d exp 000/2", i, {v_vsync, v_hsync, v_de, v_pixel}, frame_count);
      end
    end
    enable = 1'b1;
    grab(98, 0);
    for (int k = 0; k < 98; k++) begin
      checks++;
      if (frm[k] !== expv(k, 2'd3, 16'd2)) begin
        errors++; $display("FAIL enable_restart k=%0d got %h exp %h", k, frm[k], expv(k, 2'd3, 16'd2));
      end
    end
    checks++;
    if (frame_count !== 16'd3) begin errors++; $display("FAIL enable_frame_count got %0d exp 3", frame_count); end
  endtask

  task automatic test_wrap();
    force dut.frame_count = 16'hFFFF;
    grab(96, 0);
    checks++;
    if (dut.fc_next !== 16'hFFFF) begin errors++; $display("FAIL wrap_hold got %h exp ffff", dut.fc_next); end
    grab(1, 0);
    checks++;
    if (dut.fc_next !== 16'h0000) begin errors++; $display("FAIL wrap_zero got %h exp 0000", dut.fc_next); end
    release dut.frame_count;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_solid();
    test_ramps();
    test_pattern_switch();
    test_rst_mid();
    test_checker();
    test_enable();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
